// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle for the bit-reverse reorder buffer: bit-reversed input from
// the FFT core, natural-order valid/ready output, and the drop/restart status pulses.
interface fft_bitrev_reorder_if #(
  parameter int FFT_N  = 1024,
  parameter int DATA_W = 16
);
  localparam int BIN_W = $clog2(FFT_N);

  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_im;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_re;
  logic [DATA_W-1:0] out_im;
  logic              out_sof;
  logic              out_eof;
  logic [BIN_W-1:0]  out_bin;
  logic              overflow;
  logic              sof_err;

  modport master (
    output in_valid, in_sof, in_re, in_im, out_ready,
    input  out_valid, out_re, out_im, out_sof, out_eof, out_bin, overflow, sof_err
  );

  modport slave (
    input  in_valid, in_sof, in_re, in_im, out_ready,
    output out_valid, out_re, out_im, out_sof, out_eof, out_bin, overflow, sof_err
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: frames are written at bit-reversed addresses and drained
// in natural bin order on a back-pressured stream; frames with no free bank are dropped.
module fft_bitrev_reorder #(
  parameter int FFT_N  = 1024,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  fft_bitrev_reorder_if.slave bus
);
  localparam int AW = $clog2(FFT_N);
  localparam logic [AW-1:0] LAST   = AW'(FFT_N - 1);
  localparam logic [AW-1:0] PENULT = AW'(FFT_N - 2);

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DROP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_PREFETCH, R_STREAM} rd_state_t;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  wr_state_t           wr_state, wr_state_d;
  rd_state_t           rd_state, rd_state_d;
  logic [AW-1:0]       wr_cnt, wr_cnt_d, widx;
  logic                wr_bank, wr_bank_d;
  logic [1:0]          full, rel_mask, set_mask;
  logic                we, set_full, start, tgt_free, wr_last;
  logic                rd_bank, rd_bank_d, rd_en, rel, hs, bin_last;
  logic [AW-1:0]       out_bin, bin_d, rd_idx;
  logic                overflow, sof_err;
  logic [2*DATA_W-1:0] mem [2*FFT_N];
  logic [2*DATA_W-1:0] rdata;

  assign start    = bus.in_valid && bus.in_sof;
  assign tgt_free = !full[wr_bank] || (rel && (rd_bank == wr_bank));
  assign wr_last  = (wr_cnt == LAST);
  assign hs       = (rd_state == R_STREAM) && bus.out_ready;
  assign bin_last = (out_bin == LAST);
  assign rel_mask = {rel & rd_bank, rel & ~rd_bank};
  assign set_mask = {set_full & wr_bank, set_full & ~wr_bank};

  // ---------------- writer ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= W_IDLE;
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
      full     <= '0;
    end else begin
      wr_state <= wr_state_d;
      wr_cnt   <= wr_cnt_d;
      wr_bank  <= wr_bank_d;
      full     <= (full & ~rel_mask) | set_mask;
    end
  end

  always_comb begin
    wr_state_d = wr_state;
    unique case (wr_state)
      W_IDLE:  if (start) wr_state_d = tgt_free ? W_WRITE : W_DROP;
      W_WRITE: if (bus.in_valid && !bus.in_sof && wr_last) wr_state_d = W_IDLE;
      W_DROP: begin
        if (start)                        wr_state_d = tgt_free ? W_WRITE : W_DROP;
        else if (bus.in_valid && wr_last) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    we        = 1'b0;
    widx      = bitrev(wr_cnt);
    wr_cnt_d  = wr_cnt;
    wr_bank_d = wr_bank;
    set_full  = 1'b0;
    overflow  = 1'b0;
    sof_err   = 1'b0;
    if (wr_state == W_WRITE) begin
      if (bus.in_valid) begin
        we = 1'b1;
        if (bus.in_sof) begin
          sof_err  = 1'b1;
          widx     = '0;
          wr_cnt_d = AW'(1);
        end else if (wr_last) begin
          set_full  = 1'b1;
          wr_bank_d = ~wr_bank;
          wr_cnt_d  = '0;
        end else begin
          wr_cnt_d = wr_cnt + 1'b1;
        end
      end
    end else if (start) begin
      // IDLE and DROP both (re)start a frame on sof; a refused frame is counted off in DROP
      wr_cnt_d = AW'(1);
      if (tgt_free) begin
        we   = 1'b1;
        widx = '0;
      end else begin
        overflow = 1'b1;
      end
    end else if (wr_state == W_DROP && bus.in_valid) begin
      wr_cnt_d = wr_last ? '0 : wr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, widx}] <= {bus.in_re, bus.in_im};
  end

  // ---------------- reader ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= R_IDLE;
      rd_bank  <= 1'b0;
      out_bin  <= '0;
    end else begin
      rd_state <= rd_state_d;
      rd_bank  <= rd_bank_d;
      out_bin  <= bin_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state;
    unique case (rd_state)
      R_IDLE:     if (full[rd_bank]) rd_state_d = R_PREFETCH;
      R_PREFETCH: rd_state_d = R_STREAM;
      R_STREAM:   if (hs && bin_last && !full[~rd_bank]) rd_state_d = R_IDLE;
      default:    rd_state_d = R_IDLE;
    endcase
  end

  // The bank is handed back once its last bin has been fetched (the output register
  // still holds it), and a waiting bank is chained without a bubble, so the reader
  // keeps pace with an unbroken input stream.
  always_comb begin
    rd_en     = 1'b0;
    rd_idx    = out_bin + 1'b1;
    rd_bank_d = rd_bank;
    bin_d     = out_bin;
    rel       = 1'b0;
    unique case (rd_state)
      R_PREFETCH: begin
        rd_en  = 1'b1;
        rd_idx = '0;
        bin_d  = '0;
      end
      R_STREAM: begin
        if (hs && !bin_last) begin
          rd_en = 1'b1;
          bin_d = out_bin + 1'b1;
          rel   = (out_bin == PENULT);
        end else if (hs) begin
          rd_bank_d = ~rd_bank;
          bin_d     = '0;
          rd_idx    = '0;
          rd_en     = full[~rd_bank];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rdata <= '0;
    else if (rd_en) rdata <= mem[{rd_bank_d, rd_idx}];
  end

  assign bus.out_valid = (rd_state == R_STREAM);
  assign bus.out_sof   = bus.out_valid && (out_bin == '0);
  assign bus.out_eof   = bus.out_valid && bin_last;
  assign bus.out_bin   = out_bin;
  assign bus.out_re    = rdata[2*DATA_W-1:DATA_W];
  assign bus.out_im    = rdata[DATA_W-1:0];
  assign bus.overflow  = overflow;
  assign bus.sof_err   = sof_err;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for the reorder buffer: an 8-point instance checks exact latency and
// ordering, a 1024-point instance covers streaming, drop, restart, backpressure and reset.
module tb_fft_bitrev_reorder;
  localparam int DW = 16;
  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int NS = 8;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          sof;
    logic          eof;
    logic [AW-1:0] bin;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_bitrev_reorder_if #(.FFT_N(N),  .DATA_W(DW)) bif();
  fft_bitrev_reorder_if #(.FFT_N(NS), .DATA_W(DW)) sif();

  fft_bitrev_reorder #(.FFT_N(N),  .DATA_W(DW)) u_dut   (.clk(clk), .rst(rst), .bus(bif));
  fft_bitrev_reorder #(.FFT_N(NS), .DATA_W(DW)) u_small (.clk(clk), .rst(rst), .bus(sif));

  int   vectors    = 0;
  int   miscompares = 0;
  int   ovf_cnt    = 0;
  int   serr_cnt   = 0;
  exp_t sb[$];
  exp_t act, exp_v, prev_out;
  logic prev_stall = 1'b0;

  function automatic int bitrev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  function automatic logic [DW-1:0] gen_re(input int base, input int idx);
    return DW'(base + idx);
  endfunction

  function automatic logic [DW-1:0] gen_im(input int base, input int idx);
    return DW'(base * 3 + idx * 7 + 11);
  endfunction

  // Output monitor: scoreboard pop on each handshake, hold-stable check under stall.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bif.overflow) ovf_cnt++;
      if (bif.sof_err)  serr_cnt++;
      act.re  = bif.out_re;
      act.im  = bif.out_im;
      act.sof = bif.out_sof;
      act.eof = bif.out_eof;
      act.bin = bif.out_bin;
      if (prev_stall) begin
        vectors++;
        if (!bif.out_valid || act !== prev_out) begin
          miscompares++;
          $display("FAIL hold_stable valid=%b got %h expected %h", bif.out_valid, act, prev_out);
        end
      end
      if (bif.out_valid && bif.out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output bin=%0d re=%h (scoreboard empty)", act.bin, act.re);
        end else begin
          exp_v = sb.pop_front();
          if (act !== exp_v) begin
            miscompares++;
            $display("FAIL scoreboard got re=%h im=%h sof=%b eof=%b bin=%0d expected re=%h im=%h sof=%b eof=%b bin=%0d",
                     act.re, act.im, act.sof, act.eof, act.bin,
                     exp_v.re, exp_v.im, exp_v.sof, exp_v.eof, exp_v.bin);
          end
        end
      end
      prev_stall = bif.out_valid && !bif.out_ready;
      prev_out   = act;
    end
  end

  task automatic send_frame(input int base, input bit keep, input bit exp_ovf, input bit exp_serr);
    exp_t e;
    int   idx;
    if (keep) begin
      for (int i = 0; i < N; i++) begin
        e.re = gen_re(base, i); e.im = gen_im(base, i);
        e.sof = (i == 0); e.eof = (i == N - 1); e.bin = AW'(i);
        sb.push_back(e);
      end
    end
    for (int k = 0; k < N; k++) begin
      idx = bitrev(k, AW);
      bif.in_valid = 1'b1;
      bif.in_sof   = (k == 0);
      bif.in_re    = gen_re(base, idx);
      bif.in_im    = gen_im(base, idx);
      if (k == 0) begin
        @(negedge clk);
        vectors++;
        if (bif.overflow !== exp_ovf || bif.sof_err !== exp_serr) begin
          miscompares++;
          $display("FAIL sof_flags base=%0d overflow=%b sof_err=%b expected %b %b",
                   base, bif.overflow, bif.sof_err, exp_ovf, exp_serr);
        end
      end
      @(posedge clk); #1;
    end
    bif.in_valid = 1'b0;
    bif.in_sof   = 1'b0;
  endtask

  task automatic send_partial(input int base, input int cnt);
    int idx;
    for (int k = 0; k < cnt; k++) begin
      idx = bitrev(k, AW);
      bif.in_valid = 1'b1;
      bif.in_sof   = (k == 0);
      bif.in_re    = gen_re(base, idx);
      bif.in_im    = gen_im(base, idx);
      @(posedge clk); #1;
    end
    bif.in_valid = 1'b0;
    bif.in_sof   = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain %0d samples outstanding, expected 0", name, sb.size());
    end
  endtask

  task automatic check_idle(input string name);
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (bif.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle out_valid=%b expected 0", name, bif.out_valid);
    end
  endtask

  task automatic test_reset();
    bif.in_valid = 0; bif.in_sof = 0; bif.in_re = '0; bif.in_im = '0; bif.out_ready = 0;
    sif.in_valid = 0; sif.in_sof = 0; sif.in_re = '0; sif.in_im = '0; sif.out_ready = 0;
    @(negedge clk);
    vectors++;
    if ({bif.out_valid, bif.out_sof, bif.out_eof, bif.out_bin, bif.out_re, bif.out_im,
         bif.overflow, bif.sof_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_big valid=%b bin=%0d re=%h im=%h expected all 0",
               bif.out_valid, bif.out_bin, bif.out_re, bif.out_im);
    end
    vectors++;
    if ({sif.out_valid, sif.out_sof, sif.out_eof, sif.out_bin, sif.out_re, sif.out_im,
         sif.overflow, sif.sof_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_small valid=%b bin=%0d re=%h expected all 0",
               sif.out_valid, sif.out_bin, sif.out_re);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_small_frame();
    int idx;
    sif.out_ready = 1'b1;
    for (int k = 0; k < NS; k++) begin
      idx = bitrev(k, 3);
      sif.in_valid = 1'b1;
      sif.in_sof   = (k == 0);
      sif.in_re    = DW'(idx);
      sif.in_im    = DW'(100 + idx);
      @(posedge clk); #1;
    end
    sif.in_valid = 1'b0;
    sif.in_sof   = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if (sif.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL small_latency cycle %0d out_valid=%b expected 0", c + 1, sif.out_valid);
      end
    end
    for (int j = 0; j < NS; j++) begin
      @(negedge clk);
      vectors++;
      if (sif.out_valid !== 1'b1 || sif.out_re !== DW'(j) || sif.out_im !== DW'(100 + j) ||
          sif.out_sof !== (j == 0) || sif.out_eof !== (j == NS - 1) || sif.out_bin !== 3'(j)) begin
        miscompares++;
        $display("FAIL small_bin%0d valid=%b re=%0d im=%0d sof=%b eof=%b bin=%0d expected 1 %0d %0d %b %b %0d",
                 j, sif.out_valid, sif.out_re, sif.out_im, sif.out_sof, sif.out_eof, sif.out_bin,
                 j, 100 + j, j == 0, j == NS - 1, j);
      end
    end
    @(negedge clk);
    vectors++;
    if (sif.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL small_end out_valid=%b expected 0", sif.out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int ovf0 = ovf_cnt;
    bif.out_ready = 1'b1;
    for (int f = 0; f < 4; f++) send_frame(1000 * (f + 1), 1'b1, 1'b0, 1'b0);
    wait_drain("b2b", 3 * N);
    vectors++;
    if (ovf_cnt - ovf0 !== 0) begin
      miscompares++;
      $display("FAIL b2b_overflow pulses=%0d expected 0", ovf_cnt - ovf0);
    end
    check_idle("b2b");
  endtask

  task automatic test_overflow();
    int ovf0 = ovf_cnt;
    bif.out_ready = 1'b0;
    send_frame(11000, 1'b1, 1'b0, 1'b0);
    send_frame(12000, 1'b1, 1'b0, 1'b0);
    send_frame(13000, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (ovf_cnt - ovf0 !== 1) begin
      miscompares++;
      $display("FAIL ovf_count pulses=%0d expected 1", ovf_cnt - ovf0);
    end
    bif.out_ready = 1'b1;
    wait_drain("ovf", 3 * N);
    check_idle("ovf");
  endtask

  task automatic test_sof_err();
    int serr0 = serr_cnt;
    bif.out_ready = 1'b1;
    send_partial(21000, 5);
    send_frame(22000, 1'b1, 1'b0, 1'b1);
    wait_drain("sof_err", 2 * N);
    vectors++;
    if (serr_cnt - serr0 !== 1) begin
      miscompares++;
      $display("FAIL sof_err_count pulses=%0d expected 1", serr_cnt - serr0);
    end
    check_idle("sof_err");
  endtask

  task automatic test_random_ready();
    bit sent = 1'b0;
    fork
      begin
        send_frame(31000, 1'b1, 1'b0, 1'b0);
        send_frame(32000, 1'b1, 1'b0, 1'b0);
        sent = 1'b1;
      end
      begin
        for (int c = 0; c < 10 * N && (!sent || sb.size() != 0); c++) begin
          bif.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    bif.out_ready = 1'b1;
    wait_drain("random", 4);
    check_idle("random");
  endtask

  task automatic test_reset_mid();
    bif.out_ready = 1'b1;
    send_frame(41000, 1'b1, 1'b0, 1'b0);
    send_partial(42000, 300);
    #3 rst = 1'b0;
    #1;
    vectors++;
    if ({bif.out_valid, bif.out_sof, bif.out_eof, bif.out_bin, bif.out_re, bif.out_im,
         bif.overflow, bif.sof_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid valid=%b bin=%0d re=%h im=%h expected all 0",
               bif.out_valid, bif.out_bin, bif.out_re, bif.out_im);
    end
    sb.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    send_frame(43000, 1'b1, 1'b0, 1'b0);
    wait_drain("reset_mid", 2 * N);
    check_idle("reset_mid");
  endtask

  initial begin
    test_reset();
    test_small_frame();
    test_back_to_back();
    test_overflow();
    test_sof_err();
    test_random_ready();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog simulation time limit reached, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1, "watchdog");
  end
endmodule
